// File: rtl/pkt_mux_pkg.sv
// pkt_mux_pkg: shared types and width helpers for the packet multiplexer.
//   state_t   : controller state (IDLE, REQ, XFER, DRAIN), also exported on
//               the top-level debug port so checkers can follow the FSM.
//   ch_width  : bits needed to index PORTS sources, never less than 1.
//   cnt_width : bits of the stall counter for a given TIMEOUT, never less
//               than 1 (TIMEOUT=0 still needs a legal, unused register).
package pkt_mux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        XFER  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    function automatic int ch_width(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/pkt_mux_arb_rr_arbiter.sv
// pkt_mux_rr_arbiter: combinational winner selection among upstream sources.
//   Build option PKT_MUX_ROUND_ROBIN_EN:
//     defined   - round robin; search starts at pointer+1 (mod PORTS) and the
//                 pointer register follows the last winner.
//     undefined - fixed priority; lowest requesting index wins, no pointer.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (pointer -> PORTS-1)
//   requests  : per-source request vector
//   update    : load the pointer with the current winner (when found)
//   winner    : index of the selected source
//   found     : at least one source is requesting
module pkt_mux_rr_arbiter
    import pkt_mux_pkg::*;
#(
    parameter  int PORTS = 4,
    localparam int CH_W  = ch_width(PORTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] requests,
    input  logic             update,
    output logic [CH_W-1:0]  winner,
    output logic             found
);

`ifdef PKT_MUX_ROUND_ROBIN_EN

    logic [CH_W-1:0] pointer;
    logic [CH_W-1:0] winner_all;
    logic [CH_W-1:0] winner_hi;
    logic            hi_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            pointer <= CH_W'(PORTS - 1);
        end else if (update && found) begin
            pointer <= winner;
        end
    end

    // Descending scan so the last assignment is the lowest index. The lowest
    // index above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        winner_all = '0;
        winner_hi  = '0;
        hi_found   = 1'b0;
        found      = 1'b0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (requests[i]) begin
                winner_all = CH_W'(i);
                found      = 1'b1;
                if (CH_W'(i) > pointer) begin
                    winner_hi = CH_W'(i);
                    hi_found  = 1'b1;
                end
            end
        end
        winner = hi_found ? winner_hi : winner_all;
    end

`else

    // No pointer state in fixed priority; these inputs are intentionally idle.
    logic unused_pointer_inputs;
    assign unused_pointer_inputs = clk ^ rst ^ update;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (requests[i]) begin
                winner = CH_W'(i);
                found  = 1'b1;
            end
        end
    end

`endif

endmodule

// File: rtl/pkt_mux_arb.sv
// pkt_mux_arb: N-to-1 packet multiplexer with request/grant arbitration on
// both sides and a one-beat output register.
//   Build option PKT_MUX_ROUND_ROBIN_EN selects round-robin arbitration
//   (default: fixed priority, lowest index wins).
// Parameters: PORTS (>=2), WIDTH (beat bits), TIMEOUT (stall cycles before
//   forced release, 0 disables).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   request, grant  : downstream channel request / grant (grant used in REQ)
//   valid, ready    : downstream beat handshake, error/data ride with valid
//   requests        : per-source packet request, held for the whole packet
//   grants, readys  : one-hot grant / ready toward the active source
//   valids, errors, datas : per-source beat, source i at datas[i*WIDTH +: WIDTH]
//   active_ch       : current or last winning source
//   timeout         : one-cycle pulse on forced release
//   state           : controller state, for observation only
// Handshake: a beat moves when valid and ready are both high in the same
//   cycle; valid never depends on ready, and a presented beat is held
//   unchanged until accepted.
module pkt_mux_arb
    import pkt_mux_pkg::*;
#(
    parameter  int PORTS   = 4,
    parameter  int WIDTH   = 8,
    parameter  int TIMEOUT = 1024,
    localparam int CH_W    = ch_width(PORTS)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   request,
    input  logic                   grant,
    output logic                   valid,
    input  logic                   ready,
    output logic                   error,
    output logic [WIDTH-1:0]       data,
    input  logic [PORTS-1:0]       requests,
    output logic [PORTS-1:0]       grants,
    input  logic [PORTS-1:0]       valids,
    output logic [PORTS-1:0]       readys,
    input  logic [PORTS-1:0]       errors,
    input  logic [WIDTH*PORTS-1:0] datas,
    output logic [CH_W-1:0]        active_ch,
    output logic                   timeout,
    output state_t                 state
);

    localparam int              CNT_W        = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] stall_cnt;
    logic [CH_W-1:0]  winner;
    logic             found;
    logic [PORTS-1:0] ch_onehot;
    logic             in_xfer;
    logic             out_free;
    logic             ch_req;
    logic             beat;
    logic             stall;
    logic             timeout_hit;
    logic [WIDTH-1:0] src_data [PORTS];

    for (genvar g = 0; g < PORTS; g++) begin : g_split
        assign src_data[g] = datas[g*WIDTH +: WIDTH];
    end

    pkt_mux_rr_arbiter #(
        .PORTS (PORTS)
    ) u_arbiter (
        .clk      (clk),
        .rst      (rst),
        .requests (requests),
        .update   (state == IDLE),
        .winner   (winner),
        .found    (found)
    );

    assign active_ch = ch;
    assign ch_onehot = PORTS'(1) << ch;
    assign in_xfer   = (state == XFER);
    // The output register can take a beat when empty or emptying this cycle.
    assign out_free  = !valid || ready;
    assign ch_req    = requests[ch];

    // Upstream-facing grant/ready are decoded from registered state so the
    // source sees ready in the same cycle the output register frees up.
    assign grants    = in_xfer ? ch_onehot : '0;
    assign readys    = (in_xfer && out_free) ? ch_onehot : '0;

    assign beat      = in_xfer && valids[ch] && out_free;
    assign stall     = ch_req && !beat;
    // Fires on the stall cycle that brings the counter to TIMEOUT.
    assign timeout_hit = (TIMEOUT != 0) && stall && (stall_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ch        <= '0;
            request   <= 1'b0;
            valid     <= 1'b0;
            error     <= 1'b0;
            data      <= '0;
            timeout   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        ch      <= winner;
                        request <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (!ch_req) begin
                        request <= 1'b0;
                        state   <= IDLE;
                    end else if (grant) begin
                        stall_cnt <= '0;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (beat) begin
                        data  <= src_data[ch];
                        error <= errors[ch];
                        valid <= 1'b1;
                    end else if (valid && ready) begin
                        valid <= 1'b0;
                    end

                    if (beat) begin
                        stall_cnt <= '0;
                    end else if (ch_req && stall_cnt != CNT_MAX) begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end

                    if (!ch_req) begin
                        state <= DRAIN;
                    end else if (timeout_hit) begin
                        timeout <= 1'b1;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Release once the registered beat (if any) has gone out.
                    if (out_free) begin
                        valid   <= 1'b0;
                        request <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_mux_arb.sv
// tb_pkt_mux_arb: directed bench for pkt_mux_arb (PORTS=4, WIDTH=8,
// TIMEOUT=8). A vector table covers reset, a single-source packet and a
// ready-throttled packet; hand sequences cover arbitration order, timeout,
// request withdrawal in REQ and reset during a transfer.
module tb_pkt_mux_arb;
    import pkt_mux_pkg::*;

    localparam int PORTS   = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 8;

    logic                   clk;
    logic                   rst;
    logic                   request;
    logic                   grant;
    logic                   valid;
    logic                   ready;
    logic                   error;
    logic [WIDTH-1:0]       data;
    logic [PORTS-1:0]       requests;
    logic [PORTS-1:0]       grants;
    logic [PORTS-1:0]       valids;
    logic [PORTS-1:0]       readys;
    logic [PORTS-1:0]       errors;
    logic [WIDTH*PORTS-1:0] datas;
    logic [1:0]             active_ch;
    logic                   timeout;
    state_t                 state;

    pkt_mux_arb #(
        .PORTS   (PORTS),
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .request   (request),
        .grant     (grant),
        .valid     (valid),
        .ready     (ready),
        .error     (error),
        .data      (data),
        .requests  (requests),
        .grants    (grants),
        .valids    (valids),
        .readys    (readys),
        .errors    (errors),
        .datas     (datas),
        .active_ch (active_ch),
        .timeout   (timeout),
        .state     (state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        state_t     st;
        logic       request;
        logic       valid;
        logic       error;
        logic [7:0] data;
        logic [3:0] grants;
        logic [3:0] readys;
        logic [1:0] ach;
        logic       to;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic [3:0]  requests;
        logic        grant;
        logic [3:0]  valids;
        logic        ready;
        logic [3:0]  errors;
        logic [31:0] datas;
        out_t        exp;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic out_t snap();
        out_t o;
        o.st      = state;
        o.request = request;
        o.valid   = valid;
        o.error   = error;
        o.data    = data;
        o.grants  = grants;
        o.readys  = readys;
        o.ach     = active_ch;
        o.to      = timeout;
        return o;
    endfunction

    function automatic logic [31:0] mk_datas(input logic [7:0] d8, input int src);
        logic [31:0] r;
        r = {4{~d8}};
        for (int i = 0; i < 4; i++) begin
            if (i == src) r[i*8 +: 8] = d8;
        end
        return r;
    endfunction

    task automatic add(input logic r, input logic [3:0] rq, input logic g,
                       input logic [3:0] vl, input logic rd, input logic [3:0] er,
                       input logic [7:0] d8, input int src,
                       input state_t st, input logic o_rq, input logic o_v,
                       input logic o_e, input logic [7:0] o_d, input logic [3:0] o_g,
                       input logic [3:0] o_r, input logic [1:0] o_ch, input logic o_to);
        vec_t v;
        v.rst = r; v.requests = rq; v.grant = g; v.valids = vl; v.ready = rd;
        v.errors = er; v.datas = mk_datas(d8, src);
        v.exp.st = st; v.exp.request = o_rq; v.exp.valid = o_v; v.exp.error = o_e;
        v.exp.data = o_d; v.exp.grants = o_g; v.exp.readys = o_r;
        v.exp.ach = o_ch; v.exp.to = o_to;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; requests = '0; grant = 1'b0; valids = '0;
        ready = 1'b1; errors = '0; datas = '0;
        step();
        rst = 1'b0;
    endtask

    // One packet from ports 1/3 competing; p is the expected winner.
    task automatic run_pkt(input int p);
        logic [7:0] e_d;
        logic [3:0] bit_p;
        bit_p = 4'(1 << p);
        e_d   = 8'(8'h10 + p);
        step();
        check("arb_state", 32'(state), 32'(REQ));
        check("arb_win", 32'(active_ch), 32'(p));
        grant = 1'b1;
        step();
        grant = 1'b0;
        check("arb_grants", 32'(grants), 32'(bit_p));
        valids = bit_p;
        step();
        valids = '0;
        check("arb_data", 32'({valid, data}), 32'({1'b1, e_d}));
        requests = 4'b1010 & ~bit_p;
        step();
        check("arb_drain", 32'(state), 32'(DRAIN));
        requests = 4'b1010;
        step();
        check("arb_idle", 32'({state, request}), 32'({IDLE, 1'b0}));
    endtask

    initial begin
        int exp_win[3];
        out_t zero_out;
        zero_out = '0;

        // vector table: inputs applied, one clock, outputs compared
        add(1, 4'b0000, 0, 4'b0000, 1, 4'b0000, 8'h00, 2, IDLE, 0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0100, 0, 4'b0000, 1, 4'b0000, 8'h00, 2, REQ,  1, 0, 0, 8'h00, 4'b0000, 4'b0000, 2, 0);
        add(0, 4'b0100, 0, 4'b0000, 1, 4'b0000, 8'h00, 2, REQ,  1, 0, 0, 8'h00, 4'b0000, 4'b0000, 2, 0);
        add(0, 4'b0100, 0, 4'b0000, 1, 4'b0000, 8'h00, 2, REQ,  1, 0, 0, 8'h00, 4'b0000, 4'b0000, 2, 0);
        add(0, 4'b0100, 1, 4'b0000, 1, 4'b0000, 8'h00, 2, XFER, 1, 0, 0, 8'h00, 4'b0100, 4'b0100, 2, 0);
        add(0, 4'b0100, 0, 4'b0100, 1, 4'b0000, 8'hA1, 2, XFER, 1, 1, 0, 8'hA1, 4'b0100, 4'b0100, 2, 0);
        add(0, 4'b0100, 0, 4'b0100, 1, 4'b0000, 8'hA2, 2, XFER, 1, 1, 0, 8'hA2, 4'b0100, 4'b0100, 2, 0);
        add(0, 4'b0100, 0, 4'b0100, 1, 4'b0100, 8'hA3, 2, XFER, 1, 1, 1, 8'hA3, 4'b0100, 4'b0100, 2, 0);
        add(0, 4'b0100, 0, 4'b0100, 1, 4'b0000, 8'hA4, 2, XFER, 1, 1, 0, 8'hA4, 4'b0100, 4'b0100, 2, 0);
        add(0, 4'b0100, 0, 4'b0100, 1, 4'b0000, 8'hA5, 2, XFER, 1, 1, 0, 8'hA5, 4'b0100, 4'b0100, 2, 0);
        add(0, 4'b0000, 0, 4'b0000, 1, 4'b0000, 8'h00, 2, DRAIN, 1, 0, 0, 8'hA5, 4'b0000, 4'b0000, 2, 0);
        add(0, 4'b0000, 0, 4'b0000, 1, 4'b0000, 8'h00, 2, IDLE, 0, 0, 0, 8'hA5, 4'b0000, 4'b0000, 2, 0);
        // port 1 packet with ready toggling
        add(0, 4'b0010, 0, 4'b0000, 1, 4'b0000, 8'h00, 1, REQ,  1, 0, 0, 8'hA5, 4'b0000, 4'b0000, 1, 0);
        add(0, 4'b0010, 1, 4'b0000, 1, 4'b0000, 8'h00, 1, XFER, 1, 0, 0, 8'hA5, 4'b0010, 4'b0010, 1, 0);
        add(0, 4'b0010, 0, 4'b0010, 1, 4'b0000, 8'hB1, 1, XFER, 1, 1, 0, 8'hB1, 4'b0010, 4'b0010, 1, 0);
        add(0, 4'b0010, 0, 4'b0010, 0, 4'b0000, 8'hB2, 1, XFER, 1, 1, 0, 8'hB1, 4'b0010, 4'b0000, 1, 0);
        add(0, 4'b0010, 0, 4'b0010, 1, 4'b0000, 8'hB2, 1, XFER, 1, 1, 0, 8'hB2, 4'b0010, 4'b0010, 1, 0);
        add(0, 4'b0010, 0, 4'b0010, 0, 4'b0000, 8'hB3, 1, XFER, 1, 1, 0, 8'hB2, 4'b0010, 4'b0000, 1, 0);
        add(0, 4'b0010, 0, 4'b0010, 1, 4'b0000, 8'hB3, 1, XFER, 1, 1, 0, 8'hB3, 4'b0010, 4'b0010, 1, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 8'h00, 1, DRAIN, 1, 1, 0, 8'hB3, 4'b0000, 4'b0000, 1, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 8'h00, 1, DRAIN, 1, 1, 0, 8'hB3, 4'b0000, 4'b0000, 1, 0);
        add(0, 4'b0000, 0, 4'b0000, 1, 4'b0000, 8'h00, 1, IDLE, 0, 0, 0, 8'hB3, 4'b0000, 4'b0000, 1, 0);

        foreach (vecs[i]) begin
            rst      = vecs[i].rst;
            requests = vecs[i].requests;
            grant    = vecs[i].grant;
            valids   = vecs[i].valids;
            ready    = vecs[i].ready;
            errors   = vecs[i].errors;
            datas    = vecs[i].datas;
            step();
            check($sformatf("vec%0d", i), 32'(snap()), 32'(vecs[i].exp));
        end

        // arbitration order, ports 1 and 3 requesting continuously
`ifdef PKT_MUX_ROUND_ROBIN_EN
        exp_win = '{1, 3, 1};
`else
        exp_win = '{1, 1, 1};
`endif
        do_reset();
        datas    = {8'h13, 8'h12, 8'h11, 8'h10};
        requests = 4'b1010;
        for (int k = 0; k < 3; k++) run_pkt(exp_win[k]);

        // timeout: port 0 stalls after one beat held by ready=0
        do_reset();
        datas    = mk_datas(8'h55, 0);
        requests = 4'b0101;
        step();
        check("to_win0", 32'(active_ch), 32'd0);
        grant = 1'b1;
        step();
        grant  = 1'b0;
        valids = 4'b0001;
        ready  = 1'b0;
        step();
        valids = '0;
        check("to_beat", 32'({valid, data}), 32'({1'b1, 8'h55}));
        for (int k = 1; k < TIMEOUT; k++) begin
            step();
            check($sformatf("to_wait%0d", k), 32'({state, timeout}), 32'({XFER, 1'b0}));
        end
        step();
        check("to_pulse", 32'({state, timeout, valid, data}), 32'({DRAIN, 1'b1, 1'b1, 8'h55}));
        ready = 1'b1;
        step();
        check("to_release", 32'({state, request, timeout, valid}), 32'({IDLE, 1'b0, 1'b0, 1'b0}));
        step();
`ifdef PKT_MUX_ROUND_ROBIN_EN
        check("to_next", 32'({state, active_ch}), 32'({REQ, 2'd2}));
`else
        check("to_next", 32'({state, active_ch}), 32'({REQ, 2'd0}));
`endif

        // request withdrawn while waiting for grant
        requests = '0;
        step();
        check("reqdrop_idle", 32'({state, request, grants}), 32'({IDLE, 1'b0, 4'b0000}));
        grant = 1'b1;
        step();
        grant = 1'b0;
        check("reqdrop_nogrant", 32'({state, request, grants}), 32'({IDLE, 1'b0, 4'b0000}));

        // reset in the middle of a transfer with a registered beat
        requests = 4'b0001;
        datas    = mk_datas(8'h77, 0);
        step();
        grant = 1'b1;
        step();
        grant  = 1'b0;
        valids = 4'b0001;
        ready  = 1'b0;
        step();
        check("rst_pre", 32'({state, valid, data}), 32'({XFER, 1'b1, 8'h77}));
        rst = 1'b1;
        step();
        check("rst_outputs", 32'(snap()), 32'(zero_out));
        rst      = 1'b0;
        requests = '0;
        valids   = '0;
        step();
        check("rst_after", 32'(snap()), 32'(zero_out));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
